uart_tx_monitor: RTL and testbench
==================================

// Module: uart_tx_monitor
// PURPOSE
//  Serial-line sink on the riscv_top Tx pin, used by the simulation bench around the core.
//  Deserialises 8N1 UART frames, emits each received byte with a 1-cycle valid strobe, flags framing errors,
//  and raises a sticky halt when a configurable end-of-program byte arrives, so the bench ends on program exit, not a fixed cycle count.
//  Synthesisable, so the same block can also loop back onto the board Rx pin.
// PARAMETERS
//  CLKS_PER_BIT  434    clk cycles per UART bit; legal >= 4
//  HALT_BYTE     8'h00  received byte value that sets halt
//  CNT_W         32     width of byte_count
// PORTS
//  clk         in   1      single clock; all state on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  rx          in   1      serial line (connect to riscv_top Tx), idle high, asynchronous to clk
//  byte_valid  out  1      1-cycle strobe: byte_data holds a good frame
//  byte_data   out  8      last good byte; held until next good frame
//  frame_err   out  1      1-cycle strobe: stop (or parity) bit bad
//  halt        out  1      sticky; set by a good frame equal to HALT_BYTE
//  byte_count  out  CNT_W  number of good frames; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n low, async): all outputs 0; FSM=IDLE; counters 0; synchroniser flops preset to 1 (idle line).
//   Reset mid-frame discards the partial frame, with no strobe.
//  Input: rx passes a 2-flop synchroniser (2 cycles latency); the FSM sees rs only.
//  Bit counter bc counts down from CLKS_PER_BIT-1 to 0; a "tick" is bc==0, then bc reloads.
//  FSM:
//   IDLE  : rs==0 -> START, bc=CLKS_PER_BIT/2-1 (sample at mid-bit).
//   START : on tick: rs==0 -> DATA, bit idx=0; rs==1 -> IDLE (glitch, no strobe).
//   DATA  : on tick shift rs into shreg LSB-first; after idx 7 -> STOP (or PARITY if enabled).
//   PARITY: on tick capture parity bit -> STOP.
//   STOP  : on tick: rs==1 and parity ok -> good frame; else -> frame_err=1 for 1 cycle and go to BREAK.
//           Good frame: byte_valid=1 and byte_data=shreg in the same cycle, byte_count+1, then IDLE.
//   BREAK : wait until rs==1 -> IDLE (no new start while line held low).
//  Latency: byte_valid is asserted 2 + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT cycles after the rx falling edge
//   (+CLKS_PER_BIT with parity), +/-1.
//  A new start bit is accepted from the cycle after the stop sample, so back-to-back frames with
//   one stop bit are lossless.
//  halt: set in the same cycle as byte_valid when the byte == HALT_BYTE; cleared only by reset.
//   Reception continues after halt.
//  byte_valid and frame_err are never high in the same cycle.
//  byte_count at all-ones plus a good frame -> 0.
// CONFIGURATION
//  UART_MON_PARITY_EN defined:
//   - frame is 8E1; PARITY state present.
//   - good frame requires the parity bit == ^data (even parity).
//   - parity mismatch -> frame_err strobe, byte dropped, go to BREAK only if rs==0, else IDLE.
//  UART_MON_PARITY_EN undefined:
//   - frame is 8N1; no PARITY state.
//   - a bit in the parity position is treated as the stop bit.
// TESTING  (CLKS_PER_BIT=4 unless noted)
//  Reset: hold rst_n=0 with rx toggling -> all outputs 0. Assert rst_n low mid-frame -> no strobe;
//   the next clean frame 8'h5A is received correctly.
//  Single frame 8'h41 (8N1) -> one byte_valid, byte_data=8'h41, byte_count=1, frame_err=0,
//   timing within the latency formula.
//  Back-to-back frames 8'h48, 8'h69, 8'h0A with no idle gap -> three strobes in order, byte_count=3.
//  Framing error: frame 8'hFF with stop bit forced 0 and rx held low 20 cycles -> one frame_err strobe,
//   no byte_valid. A following 8'h33 is received correctly.
//  Glitch: rx low for 1 cycle -> FSM back to IDLE, no strobes.
//  Halt: frames 8'h31 then HALT_BYTE=8'h00 -> halt rises with the second byte_valid and stays 1.
//   A further frame 8'h32 still strobes, byte_count=3.
//  With UART_MON_PARITY_EN:
//   - 8'h07 with parity 1 -> good frame.
//   - 8'h07 with parity 0 -> frame_err strobe.

Source files
------------

// File: rtl/uart_tx_monitor.sv
// uart_tx_monitor
//   Serial-line sink for a UART Tx pin. It deserialises 8N1 frames, or 8E1
//   frames when UART_MON_PARITY_EN is defined. Each good byte is presented
//   with a one-cycle strobe. A bad stop bit or a bad parity bit raises a
//   one-cycle error strobe. A good byte equal to HALT_BYTE sets a sticky
//   halt flag. Reception continues after halt.
//
//   Optional feature macro: UART_MON_PARITY_EN (even parity, 8E1 frames)
//
// Ports
//   clk         single clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   byte_valid  1-cycle strobe, byte_data holds a good frame
//   byte_data   last good byte, held until the next good frame
//   frame_err   1-cycle strobe, stop or parity bit bad
//   halt        sticky, set by a good frame equal to HALT_BYTE
//   byte_count  number of good frames, wraps modulo 2^CNT_W
module uart_tx_monitor #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HALT_BYTE    = 8'h00,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             frame_err,
  output logic             halt,
  output logic [CNT_W-1:0] byte_count
);

  localparam int              BC_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(CLKS_PER_BIT - 1);
  localparam logic [BC_W-1:0] BC_HALF = BC_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_MON_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  state_t           state, state_n;
  logic             rx_p0, rx_p1;
  logic [BC_W-1:0]  bc, bc_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             byte_valid_n, frame_err_n, halt_n;
  logic [7:0]       byte_data_n;
  logic [CNT_W-1:0] byte_count_n;
  logic             rs, tick, par_ok;

`ifdef UART_MON_PARITY_EN
  logic par, par_n;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  assign par_ok = (par == even_par(shreg));
`else
  assign par_ok = 1'b1;
`endif

  // ---- p0/p1: two-flop synchroniser, preset to the idle-high line level ----
  assign rs   = rx_p1;
  assign tick = (bc == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      state      <= IDLE;
      bc         <= '0;
      idx        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
      halt       <= 1'b0;
      byte_count <= '0;
    end else begin
      rx_p0      <= rx;
      rx_p1      <= rx_p0;
      state      <= state_n;
      bc         <= bc_n;
      idx        <= idx_n;
      byte_valid <= byte_valid_n;
      byte_data  <= byte_data_n;
      frame_err  <= frame_err_n;
      halt       <= halt_n;
      byte_count <= byte_count_n;
    end
  end

  // ---- frame datapath: shift register needs no reset ----
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
`ifdef UART_MON_PARITY_EN
    par   <= par_n;
`endif
  end

  // ---- frame FSM: samples rs once per bit, at mid-bit ----
  always_comb begin
    state_n      = state;
    bc_n         = bc;
    idx_n        = idx;
    shreg_n      = shreg;
`ifdef UART_MON_PARITY_EN
    par_n        = par;
`endif
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    byte_data_n  = byte_data;
    halt_n       = halt;
    byte_count_n = byte_count;

    if (state != IDLE && state != BRK)
      bc_n = tick ? BC_FULL : bc - BC_W'(1);

    case (state)
      IDLE: begin
        if (!rs) begin
          state_n = START;
          bc_n    = BC_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!rs) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = {rs, shreg[7:1]};
          if (idx == 3'd7) begin
`ifdef UART_MON_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
`ifdef UART_MON_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_n   = rs;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!rs) begin
            // Line still low: wait for it to return high before the next start.
            frame_err_n = 1'b1;
            state_n     = BRK;
          end else if (!par_ok) begin
            frame_err_n = 1'b1;
            state_n     = IDLE;
          end else begin
            byte_valid_n = 1'b1;
            byte_data_n  = shreg;
            byte_count_n = byte_count + CNT_W'(1);
            if (shreg == HALT_BYTE)
              halt_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      BRK: begin
        if (rs)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_monitor.sv
// tb_uart_tx_monitor
//   Directed bench for uart_tx_monitor with CLKS_PER_BIT=4 and HALT_BYTE=8'h00.
//   CNT_W=3 makes the byte_count wrap reachable in a short frame sequence.
//   A table of frames runs back to back. A negedge monitor logs every strobe.
//   Reset, glitch, mid-frame reset, halt and (optionally) parity cases are
//   hand-written sequences.
module tb_uart_tx_monitor;

  localparam int         CPB   = 4;
  localparam int         CNT_W = 3;
  localparam logic [7:0] HALTB = 8'h00;
`ifdef UART_MON_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx = 1'b1;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             frame_err;
  logic             halt;
  logic [CNT_W-1:0] byte_count;
`ifdef UART_MON_PARITY_EN
  logic             par_flip = 1'b0;
`endif

  uart_tx_monitor #(
    .CLKS_PER_BIT(CPB),
    .HALT_BYTE   (HALTB),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .halt      (halt),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]       data;
    logic [CNT_W-1:0] cnt;
    logic             hlt;
    int               t;
  } rec_t;

  rec_t got_q[$];
  int   err_strobes = 0;
  int   overlap = 0;

  always @(negedge clk) begin
    if (byte_valid) got_q.push_back('{data: byte_data, cnt: byte_count, hlt: halt, t: cyc});
    if (frame_err) err_strobes++;
    if (byte_valid && frame_err) overlap++;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    err_strobes = 0;
  endtask

  task automatic do_reset();
    rx    = 1'b1;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3);
    clear_log();
  endtask

  // Drives one frame; a 0 stop bit is followed by 20 further low cycles.
  task automatic send_frame(input logic [7:0] d, input logic stopv, input int gap,
                            output int t0);
    t0 = cyc;
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(CPB);
    end
`ifdef UART_MON_PARITY_EN
    rx = (^d) ^ par_flip;
    step(CPB);
`endif
    rx = stopv;
    step(CPB);
    if (!stopv) step(20);
    rx = 1'b1;
    step(gap);
  endtask

  typedef struct {
    logic [7:0]       d;
    logic             stopv;
    int               gap;
    logic             ev;
    logic             ee;
    logic [CNT_W-1:0] ecnt;
  } vec_t;

  vec_t tbl[10];
  int   t_start[10];

  initial begin
    int   t0;
    int   qi;
    int   exp_nv;
    int   exp_ne;
    rec_t r;

    tbl[0] = '{d: 8'h41, stopv: 1'b1, gap: 8, ev: 1'b1, ee: 1'b0, ecnt: 3'd1};
    tbl[1] = '{d: 8'h48, stopv: 1'b1, gap: 0, ev: 1'b1, ee: 1'b0, ecnt: 3'd2};
    tbl[2] = '{d: 8'h69, stopv: 1'b1, gap: 0, ev: 1'b1, ee: 1'b0, ecnt: 3'd3};
    tbl[3] = '{d: 8'h0A, stopv: 1'b1, gap: 8, ev: 1'b1, ee: 1'b0, ecnt: 3'd4};
    tbl[4] = '{d: 8'hFF, stopv: 1'b0, gap: 8, ev: 1'b0, ee: 1'b1, ecnt: 3'd4};
    tbl[5] = '{d: 8'h33, stopv: 1'b1, gap: 8, ev: 1'b1, ee: 1'b0, ecnt: 3'd5};
    tbl[6] = '{d: 8'h5A, stopv: 1'b1, gap: 0, ev: 1'b1, ee: 1'b0, ecnt: 3'd6};
    tbl[7] = '{d: 8'hA5, stopv: 1'b1, gap: 0, ev: 1'b1, ee: 1'b0, ecnt: 3'd7};
    tbl[8] = '{d: 8'h01, stopv: 1'b1, gap: 8, ev: 1'b1, ee: 1'b0, ecnt: 3'd0};
    tbl[9] = '{d: 8'h80, stopv: 1'b1, gap: 8, ev: 1'b1, ee: 1'b0, ecnt: 3'd1};

    // Reset held with rx toggling
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx = ~rx;
      step(1);
    end
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_data", 32'(byte_data), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
    rx = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(10);
    check("rst_no_valid", 32'(got_q.size()), 32'd0);
    check("rst_no_err", 32'(err_strobes), 32'd0);

    // Table of frames, sent back to back where gap is 0
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].d, tbl[i].stopv, tbl[i].gap, t0);
      t_start[i] = t0;
    end
    step(10);
    qi = 0;
    exp_nv = 0;
    exp_ne = 0;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].ee) exp_ne++;
      if (tbl[i].ev) begin
        exp_nv++;
        if (qi < got_q.size()) begin
          r = got_q[qi];
          check($sformatf("tbl%0d_data", i), 32'(r.data), 32'(tbl[i].d));
          check($sformatf("tbl%0d_count", i), 32'(r.cnt), 32'(tbl[i].ecnt));
          check($sformatf("tbl%0d_halt", i), 32'(r.hlt), 32'd0);
          check_range($sformatf("tbl%0d_latency", i), r.t - t_start[i], LAT - 1, LAT + 1);
        end else begin
          n_checks++;
          $display("FAIL tbl%0d_strobe: got none expected data %0h", i, tbl[i].d);
        end
        qi++;
      end
    end
    check("tbl_nvalid", 32'(got_q.size()), 32'(exp_nv));
    check("tbl_nerr", 32'(err_strobes), 32'(exp_ne));
    check("tbl_final_count", 32'(byte_count), 32'(tbl[9].ecnt));
    check("tbl_final_data", 32'(byte_data), 32'(tbl[9].d));

    // One-cycle glitch, then a clean frame
    do_reset();
    rx = 1'b0;
    step(1);
    rx = 1'b1;
    step(20);
    check("glitch_no_valid", 32'(got_q.size()), 32'd0);
    check("glitch_no_err", 32'(err_strobes), 32'd0);
    send_frame(8'h41, 1'b1, 8, t0);
    check("glitch_next_n", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("glitch_next_data", 32'(got_q[0].data), 32'h41);

    // Reset in the middle of a frame
    do_reset();
    rx = 1'b0;
    step(CPB);
    rx = 1'b1;
    step(CPB);
    rx = 1'b1;
    step(CPB);
    rx = 1'b0;
    step(2);
    rst_n = 1'b0;
    check("midrst_valid", 32'(byte_valid), 32'd0);
    step(2);
    rx = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(60);
    check("midrst_no_valid", 32'(got_q.size()), 32'd0);
    check("midrst_no_err", 32'(err_strobes), 32'd0);
    check("midrst_count", 32'(byte_count), 32'd0);
    send_frame(8'h5A, 1'b1, 8, t0);
    check("midrst_next_n", 32'(got_q.size()), 32'd1);
    check("midrst_next_data", 32'(byte_data), 32'h5A);
    check("midrst_next_count", 32'(byte_count), 32'd1);

    // Halt on HALT_BYTE, reception continues afterwards
    do_reset();
    send_frame(8'h31, 1'b1, 8, t0);
    check("halt_before", 32'(halt), 32'd0);
    send_frame(HALTB, 1'b1, 8, t0);
    send_frame(8'h32, 1'b1, 8, t0);
    check("halt_n", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("halt_s0_halt", 32'(got_q[0].hlt), 32'd0);
      check("halt_s1_data", 32'(got_q[1].data), 32'(HALTB));
      check("halt_s1_halt", 32'(got_q[1].hlt), 32'd1);
      check("halt_s2_data", 32'(got_q[2].data), 32'h32);
      check("halt_s2_halt", 32'(got_q[2].hlt), 32'd1);
    end
    check("halt_count", 32'(byte_count), 32'd3);
    check("halt_sticky", 32'(halt), 32'd1);

`ifdef UART_MON_PARITY_EN
    // Even parity: 8'h07 has three ones, so a good frame carries parity 1
    do_reset();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 8, t0);
    check("par_good_n", 32'(got_q.size()), 32'd1);
    check("par_good_data", 32'(byte_data), 32'h07);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 8, t0);
    par_flip = 1'b0;
    check("par_bad_err", 32'(err_strobes), 32'd1);
    check("par_bad_no_valid", 32'(got_q.size()), 32'd1);
    send_frame(8'h33, 1'b1, 8, t0);
    check("par_next_data", 32'(byte_data), 32'h33);
    check("par_next_count", 32'(byte_count), 32'd2);
`endif

    check("no_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
